serial_bit_feeder: RTL and testbench
====================================

// Module: serial_bit_feeder
// PURPOSE
//   Upstream stage of the serial sequence detectors.
//   Accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock on bit_out.
//   Between words it drives a fixed idle level so the detector sees no spurious pattern.
//   An optional even-parity bit is appended after each word.
// PARAMETERS
//   WIDTH       8  data word width in bits, >= 2
//   MSB_FIRST   1  1: bit WIDTH-1 shifted first; 0: bit 0 shifted first
//   GAP_CYCLES  0  idle cycles inserted after each word (0..255)
//   IDLE_BIT    0  bit_out level when no data bit is being driven
// PORTS
//   clk         in   1      rising-edge clock
//   reset_n     in   1      asynchronous, active-low reset
//   load_data   in   WIDTH  parallel word; sampled only on handshake
//   load_valid  in   1      producer offers load_data
//   load_ready  out  1      feeder can accept a word this cycle (combinational)
//   bit_out     out  1      serial data to the detector's input (registered)
//   bit_valid   out  1      1 while bit_out carries a data or parity bit (registered)
//   busy        out  1      1 in any state other than IDLE
// BEHAVIOUR
//   Reset (async, reset_n=0):
//     - state=IDLE; shift reg, bit counter, gap counter cleared.
//     - bit_out=IDLE_BIT, bit_valid=0, busy=0; load_ready=1 once reset_n=1.
//     - Reset mid-word abandons the word immediately; no partial-word completion.
//   FSM states:
//     - IDLE:  load_ready=1. On load_valid&load_ready -> SHIFT, capture load_data.
//     - SHIFT: one bit per cycle, bit_valid=1. Counter runs WIDTH-1..0.
//       After the last bit: -> PARITY if the macro is defined, else -> GAP if GAP_CYCLES>0, else IDLE.
//     - PARITY: one cycle; bit_out = XOR of the captured word, bit_valid=1. Then -> GAP or IDLE.
//     - GAP:   GAP_CYCLES cycles with bit_out=IDLE_BIT, bit_valid=0. Then -> IDLE.
//   Latency:
//     - Handshake at edge k: first bit is visible from edge k+1.
//     - Word occupies WIDTH (+1 with parity) consecutive valid cycles.
//   Back-to-back:
//     - When GAP_CYCLES==0, load_ready is also 1 in the final output cycle (last SHIFT bit, or PARITY).
//     - A handshake there reloads and continues SHIFT with no bubble.
//     - The same applies in the final GAP cycle when GAP_CYCLES>0.
//   Other rules:
//     - load_valid without load_ready: no effect, and load_data is not sampled.
//     - load_data changes after capture are ignored.
//     - Counters are saturation-free: sized $clog2(WIDTH) and $clog2(GAP_CYCLES+1) (min 1 bit).
//     - Their terminal counts must be exact; no wrap past them.
// CONFIGURATION
//   FEEDER_PARITY_EN
//     - Defined: PARITY state present; each word is WIDTH+1 valid bits, the last being even parity.
//     - Undefined: no PARITY state, no parity logic; word is WIDTH bits.
// STRUCTURE
//   Package serial_feed_pkg:
//     - state encoding localparams (ST_IDLE, ST_SHIFT, ST_PARITY, ST_GAP).
//     - function clog2_min1 for counter widths.
//   No sub-module: shift register, counters and FSM in one module.
// TESTING
//   Defaults unless noted; a 1101 detector is attached on bit_out for end-to-end checks.
//   1. Reset, load 8'hD0
//        -> bit_out 1,1,0,1,0,0,0,0 with bit_valid=1 for 8 cycles; detector flags one 1101.
//   2. load_valid held with 8'hA5 then 8'h3C
//        -> 16 contiguous valid bits 10100101_00111100.
//        -> load_ready=1 only in IDLE and on the 8th bit.
//   3. GAP_CYCLES=2, two words
//        -> exactly 2 cycles of bit_valid=0, bit_out=0 between them; busy stays 1 through the gap.
//   4. reset_n low on the 4th bit of 8'hFF
//        -> bit_out=0, bit_valid=0 asynchronously.
//        -> after release, load_ready=1 and the next word 8'h0F shifts out intact.
//   5. MSB_FIRST=0, load 8'hD0 -> bit_out 0,0,0,0,1,0,1,1.
//   6. FEEDER_PARITY_EN defined, load 8'h07
//        -> 00000111 then parity 1; 9 valid cycles; 8'h03 gives parity 0.

Source files
------------

// File: rtl/serial_feed_pkg.sv
// Shared definitions for the serial bit feeder.
//   feed_state_t : FSM state encoding (ST_IDLE, ST_SHIFT, ST_PARITY, ST_GAP)
//   clog2_min1   : counter width helper, never returns less than 1 bit
package serial_feed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } feed_state_t;

  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
//   Accepts a parallel word over a valid/ready handshake and shifts it out
//   one bit per clock on bit_out. Between words bit_out holds IDLE_BIT.
//   Optional even-parity bit after each word: define FEEDER_PARITY_EN.
// Parameters
//   WIDTH      data word width (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   GAP_CYCLES idle cycles inserted after each word (0..255)
//   IDLE_BIT   bit_out level when no data/parity bit is driven
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   load_data  parallel word, sampled only on handshake
//   load_valid producer offers load_data
//   load_ready feeder accepts a word this cycle (combinational)
//   bit_out    serial data (registered)
//   bit_valid  bit_out carries a data or parity bit (registered)
//   busy       FSM is not in IDLE
module serial_bit_feeder
  import serial_feed_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          IDLE_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy
);

  localparam int unsigned CNT_W = clog2_min1(WIDTH);
  localparam int unsigned GAP_W = clog2_min1(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  feed_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
`ifdef FEEDER_PARITY_EN
  logic             parity_bit;
`endif

  logic             last_out;
  logic             load_fire;
  logic             first_bit;
  logic [WIDTH-1:0] shreg_init;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_next;

  // shreg holds only the bits not yet presented; the first bit goes straight
  // to bit_out at capture so it is visible one edge after the handshake.
  always_comb begin
    first_bit  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    shreg_init = MSB_FIRST ? {load_data[WIDTH-2:0], 1'b0} : {1'b0, load_data[WIDTH-1:1]};
    next_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  end

  // Final output cycle of a word: last data bit, or the parity bit.
  always_comb begin
`ifdef FEEDER_PARITY_EN
    last_out = (state == ST_PARITY);
`else
    last_out = (state == ST_SHIFT) && (bit_cnt == '0);
`endif
    load_ready = (state == ST_IDLE)
               || (last_out && (GAP_CYCLES == 0))
               || ((state == ST_GAP) && (gap_cnt == '0));
    load_fire  = load_valid && load_ready;
  end

  assign busy = (state != ST_IDLE);

  // A handshake can only occur in IDLE or a final cycle, so servicing it
  // ahead of the per-state case gives the zero-bubble reload directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      bit_out    <= IDLE_BIT;
      bit_valid  <= 1'b0;
`ifdef FEEDER_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (load_fire) begin
      state      <= ST_SHIFT;
      shreg      <= shreg_init;
      bit_cnt    <= CNT_LAST;
      bit_out    <= first_bit;
      bit_valid  <= 1'b1;
`ifdef FEEDER_PARITY_EN
      parity_bit <= ^load_data;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          bit_out   <= IDLE_BIT;
          bit_valid <= 1'b0;
        end
        ST_SHIFT: begin
          if (bit_cnt != '0) begin
            shreg   <= shreg_next;
            bit_out <= next_bit;
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
`ifdef FEEDER_PARITY_EN
            state   <= ST_PARITY;
            bit_out <= parity_bit;
`else
            state     <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            gap_cnt   <= GAP_INIT;
            bit_out   <= IDLE_BIT;
            bit_valid <= 1'b0;
`endif
          end
        end
`ifdef FEEDER_PARITY_EN
        ST_PARITY: begin
          state     <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
          gap_cnt   <= GAP_INIT;
          bit_out   <= IDLE_BIT;
          bit_valid <= 1'b0;
        end
`endif
        ST_GAP: begin
          bit_out   <= IDLE_BIT;
          bit_valid <= 1'b0;
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bit_out   <= IDLE_BIT;
          bit_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Testbench for serial_bit_feeder: three instances (defaults, GAP_CYCLES=2,
// MSB_FIRST=0). Expected serial bits are queued at each handshake and a
// negedge monitor pops and compares whenever bit_valid is high. A 1101
// detector watches the default instance. Build with FEEDER_PARITY_EN to
// cover the parity variant.
module tb_serial_bit_feeder;

`ifdef FEEDER_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  localparam int WLEN = 8 + (PAR_ON ? 1 : 0);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn0, rn1, rn2;
  logic       lv0, lv1, lv2;
  logic [7:0] ld0, ld1, ld2;
  logic       lr0, lr1, lr2;
  logic       bo0, bo1, bo2;
  logic       bv0, bv1, bv2;
  logic       by0, by1, by2;

  serial_bit_feeder u_dut (
    .clk(clk), .reset_n(rn0), .load_data(ld0), .load_valid(lv0),
    .load_ready(lr0), .bit_out(bo0), .bit_valid(bv0), .busy(by0)
  );

  serial_bit_feeder #(.GAP_CYCLES(2)) u_gap (
    .clk(clk), .reset_n(rn1), .load_data(ld1), .load_valid(lv1),
    .load_ready(lr1), .bit_out(bo1), .bit_valid(bv1), .busy(by1)
  );

  serial_bit_feeder #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(rn2), .load_data(ld2), .load_valid(lv2),
    .load_ready(lr2), .bit_out(bo2), .bit_valid(bv2), .busy(by2)
  );

  int tests = 0;
  int fails = 0;

  bit q0[$];
  bit q1[$];
  bit q2[$];

  int run[3], last_run[3], zrun[3], zbusy[3], last_gap[3], last_gap_busy[3];
  logic [3:0] hist;
  int det_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic get_lr(input int idx);
    case (idx)
      0: return lr0;
      1: return lr1;
      default: return lr2;
    endcase
  endfunction

  function automatic logic get_busy(input int idx);
    case (idx)
      0: return by0;
      1: return by1;
      default: return by2;
    endcase
  endfunction

  task automatic set_in(input int idx, input logic v, input logic [7:0] d);
    case (idx)
      0: begin lv0 = v; ld0 = d; end
      1: begin lv1 = v; ld1 = d; end
      default: begin lv2 = v; ld2 = d; end
    endcase
  endtask

  // seq lists the bits in output order, first bit in seq[7].
  task automatic push_word(input int idx, input logic [7:0] seq, input bit par);
    for (int i = 7; i >= 0; i--) begin
      case (idx)
        0: q0.push_back(seq[i]);
        1: q1.push_back(seq[i]);
        default: q2.push_back(seq[i]);
      endcase
    end
    if (PAR_ON) begin
      case (idx)
        0: q0.push_back(par);
        1: q1.push_back(par);
        default: q2.push_back(par);
      endcase
    end
  endtask

  // Offer a word and wait for the handshake edge; waited counts edges at
  // which load_ready was low. After capture the data bus is scrambled.
  task automatic do_load(input int idx, input logic [7:0] data, input bit keep, output int waited);
    logic r;
    bit ok;
    set_in(idx, 1'b1, data);
    waited = 0;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      r = get_lr(idx);
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) chk("handshake_timeout", 0, 1);
    if (!keep) set_in(idx, 1'b0, ~data);
  endtask

  task automatic wait_idle(input int idx);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      #1;
      if (!get_busy(idx)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic track(input int i, input logic v, input logic b);
    if (v) begin
      if (zrun[i] > 0) begin
        last_gap[i] = zrun[i];
        last_gap_busy[i] = zbusy[i];
      end
      zrun[i] = 0;
      zbusy[i] = 0;
      run[i]++;
    end else begin
      if (run[i] > 0) last_run[i] = run[i];
      run[i] = 0;
      zrun[i]++;
      if (b) zbusy[i]++;
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    bit e;
    if (bv0) begin
      if (q0.size() == 0) chk("u_dut_extra_bit", 1, 0);
      else begin e = q0.pop_front(); chk("u_dut_bit", bo0, e); end
      hist = {hist[2:0], bo0};
      if (hist == 4'b1101) det_cnt++;
    end else begin
      chk("u_dut_idle_level", bo0, 0);
    end
    if (!rn0) hist = '0;
    if (bv1) begin
      if (q1.size() == 0) chk("u_gap_extra_bit", 1, 0);
      else begin e = q1.pop_front(); chk("u_gap_bit", bo1, e); end
    end else begin
      chk("u_gap_idle_level", bo1, 0);
    end
    if (bv2) begin
      if (q2.size() == 0) chk("u_lsb_extra_bit", 1, 0);
      else begin e = q2.pop_front(); chk("u_lsb_bit", bo2, e); end
    end else begin
      chk("u_lsb_idle_level", bo2, 0);
    end
    track(0, bv0, by0);
    track(1, bv1, by1);
    track(2, bv2, by2);
  end

  initial begin
    int w;
    for (int i = 0; i < 3; i++) begin
      run[i] = 0; last_run[i] = 0; zrun[i] = 0; zbusy[i] = 0;
      last_gap[i] = 0; last_gap_busy[i] = 0;
    end
    hist = '0;
    det_cnt = 0;
    rn0 = 1'b0; rn1 = 1'b0; rn2 = 1'b0;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    set_in(2, 1'b0, 8'h00);

    // Reset state
    #12;
    chk("reset_bit_out", {29'd0, bo0, bo1, bo2}, 0);
    chk("reset_bit_valid", {29'd0, bv0, bv1, bv2}, 0);
    chk("reset_busy", {29'd0, by0, by1, by2}, 0);
    @(negedge clk);
    rn0 = 1'b1; rn1 = 1'b1; rn2 = 1'b1;
    #1;
    chk("reset_load_ready", {29'd0, lr0, lr1, lr2}, 3'b111);

    // 1: single word D0, MSB first
    do_load(0, 8'hD0, 1'b0, w);
    chk("t1_ready_in_idle_wait", w, 0);
    push_word(0, 8'b1101_0000, 1'b1);
    wait_idle(0);
    chk("t1_valid_run", last_run[0], WLEN);
    chk("t1_detector_1101", det_cnt, 1);

    // 2: valid held, A5 then 3C back-to-back
    do_load(0, 8'hA5, 1'b1, w);
    chk("t2_first_wait", w, 0);
    push_word(0, 8'b1010_0101, 1'b0);
    do_load(0, 8'h3C, 1'b0, w);
    chk("t2_ready_low_cycles", w, WLEN - 1);
    push_word(0, 8'b0011_1100, 1'b0);
    wait_idle(0);
    chk("t2_contiguous_run", last_run[0], 2 * WLEN);

    // 3: GAP_CYCLES=2, two words with valid held
    do_load(1, 8'hB4, 1'b1, w);
    push_word(1, 8'b1011_0100, 1'b0);
    do_load(1, 8'h6D, 1'b0, w);
    chk("t3_ready_low_cycles", w, WLEN - 1 + 2);
    push_word(1, 8'b0110_1101, 1'b1);
    wait_idle(1);
    chk("t3_gap_len", last_gap[1], 2);
    chk("t3_busy_in_gap", last_gap_busy[1], 2);
    chk("t3_second_run", last_run[1], WLEN);

    // 4: reset during the 4th bit of FF
    do_load(0, 8'hFF, 1'b0, w);
    push_word(0, 8'b1111_1111, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rn0 = 1'b0;
    q0.delete();
    #1;
    chk("t4_async_bit_out", bo0, 0);
    chk("t4_async_bit_valid", bv0, 0);
    chk("t4_async_busy", by0, 0);
    chk("t4_partial_run", run[0], 3);
    @(negedge clk);
    @(negedge clk);
    rn0 = 1'b1;
    #1;
    chk("t4_ready_after_release", lr0, 1);
    do_load(0, 8'h0F, 1'b0, w);
    chk("t4_reload_wait", w, 0);
    push_word(0, 8'b0000_1111, 1'b0);
    wait_idle(0);
    chk("t4_reload_run", last_run[0], WLEN);

    // 5: LSB first, D0
    do_load(2, 8'hD0, 1'b0, w);
    push_word(2, 8'b0000_1011, 1'b1);
    wait_idle(2);
    chk("t5_lsb_run", last_run[2], WLEN);

    // 6: parity words (parity bits queued only in the parity build)
    do_load(0, 8'h07, 1'b0, w);
    push_word(0, 8'b0000_0111, 1'b1);
    wait_idle(0);
    chk("t6_run_07", last_run[0], WLEN);
    do_load(0, 8'h03, 1'b0, w);
    push_word(0, 8'b0000_0011, 1'b0);
    wait_idle(0);
    chk("t6_run_03", last_run[0], WLEN);

    repeat (4) @(negedge clk);
    #1;
    chk("drain_u_dut", q0.size(), 0);
    chk("drain_u_gap", q1.size(), 0);
    chk("drain_u_lsb", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
